// File: rtl/fnanunbox_pkg.sv
// rtl/fnanunbox_pkg.sv - shared FPU config: format widths and fclass bit positions
package fnanunbox_pkg;

  localparam int FLEN    = 64;
  localparam int LEN1    = 32;
  localparam int NE      = 11;
  localparam int NF      = 52;
  localparam int NE1     = 8;
  localparam int NF1     = 23;
  localparam int FPSIZES = 2;
  localparam int FMTBITS = 1;
  localparam int NCLASS  = 10;

  localparam int FCLASS_NEGINF  = 0;
  localparam int FCLASS_NEGNORM = 1;
  localparam int FCLASS_NEGSUB  = 2;
  localparam int FCLASS_NEGZERO = 3;
  localparam int FCLASS_POSZERO = 4;
  localparam int FCLASS_POSSUB  = 5;
  localparam int FCLASS_POSNORM = 6;
  localparam int FCLASS_POSINF  = 7;
  localparam int FCLASS_SNAN    = 8;
  localparam int FCLASS_QNAN    = 9;

  localparam logic [NCLASS-1:0] CANON_NAN_CLASS = 10'h200;

endpackage

// File: rtl/fnanunbox_fclassify.sv
// rtl/fnanunbox_fclassify.sv - combinational fclass mask from pre-decoded field flags
module fclassify
  import fnanunbox_pkg::*;
(
  input  logic              sgn,
  input  logic              expones,
  input  logic              expzero,
  input  logic              fraczero,
  input  logic              fracmsb,
  input  logic              boxok,
  output logic [NCLASS-1:0] classres
);

  always_comb begin
    classres = '0;
    if (!boxok) begin
      classres = CANON_NAN_CLASS;
    end else if (expones) begin
      if (fraczero)     classres[sgn ? FCLASS_NEGINF : FCLASS_POSINF] = 1'b1;
      else if (fracmsb) classres[FCLASS_QNAN] = 1'b1;
      else              classres[FCLASS_SNAN] = 1'b1;
    end else if (expzero) begin
      if (fraczero) classres[sgn ? FCLASS_NEGZERO : FCLASS_POSZERO] = 1'b1;
      else          classres[sgn ? FCLASS_NEGSUB : FCLASS_POSSUB] = 1'b1;
    end else begin
      classres[sgn ? FCLASS_NEGNORM : FCLASS_POSNORM] = 1'b1;
    end
  end

endmodule

// File: rtl/fnanunbox.sv
// rtl/fnanunbox.sv - two-stage NaN-box checker and operand classifier with valid/ready
module fnanunbox #(
  parameter int FLEN    = fnanunbox_pkg::FLEN,
  parameter int FPSIZES = fnanunbox_pkg::FPSIZES,
  parameter int LEN1    = fnanunbox_pkg::LEN1,
  parameter int NE      = fnanunbox_pkg::NE,
  parameter int NF      = fnanunbox_pkg::NF,
  parameter int NE1     = fnanunbox_pkg::NE1,
  parameter int NF1     = fnanunbox_pkg::NF1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic [FLEN-1:0]                    X,
  input  logic [fnanunbox_pkg::FMTBITS-1:0]  Fmt,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic                               Sgn,
  output logic                               BoxOk,
  output logic [fnanunbox_pkg::NCLASS-1:0]   ClassRes
);
  import fnanunbox_pkg::*;

  logic            v1, v2;
  logic            adv1, adv2, accept;
  logic [FLEN-1:0] x1;
  logic            fmt1;

  logic s1_sgn, s1_box, s1_expones, s1_expzero, s1_fraczero, s1_fracmsb;
  logic s2_sgn, s2_box, s2_expones, s2_expzero, s2_fraczero, s2_fracmsb;
  logic [NCLASS-1:0] s2_class;

  assign adv2    = ~v2 | OutReady;
  assign adv1    = ~v1 | adv2;
  assign InReady = ~reset & adv1;
  assign accept  = InValid & InReady;

  // Wide-format flags are always computed; the narrow format muxes over them.
  logic [NE-1:0] d_exp;
  logic [NF-1:0] d_frac;
  assign d_exp  = x1[FLEN-2 -: NE];
  assign d_frac = x1[NF-1:0];

  generate
    if (FPSIZES == 2) begin : g_two
      logic [NE1-1:0] s_exp;
      logic [NF1-1:0] s_frac;
      assign s_exp  = x1[LEN1-2 -: NE1];
      assign s_frac = x1[NF1-1:0];
      always_comb begin
        s1_box      = fmt1 | (&x1[FLEN-1:LEN1]);
        s1_sgn      = fmt1 ? x1[FLEN-1] : x1[LEN1-1];
        s1_expones  = fmt1 ? (&d_exp)   : (&s_exp);
        s1_expzero  = fmt1 ? ~(|d_exp)  : ~(|s_exp);
        s1_fraczero = fmt1 ? ~(|d_frac) : ~(|s_frac);
        s1_fracmsb  = fmt1 ? d_frac[NF-1] : s_frac[NF1-1];
      end
    end else if (FPSIZES == 1) begin : g_one
      always_comb begin
        s1_box      = 1'b1;
        s1_sgn      = x1[FLEN-1];
        s1_expones  = &d_exp;
        s1_expzero  = ~(|d_exp);
        s1_fraczero = ~(|d_frac);
        s1_fracmsb  = d_frac[NF-1];
      end
    end else begin : g_bad
      $error("fnanunbox: FPSIZES must be 1 or 2");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (adv1) v1 <= InValid;
      if (adv2) v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x1   <= X;
      fmt1 <= Fmt[0];
    end
    if (adv2 && v1) begin
      s2_sgn      <= s1_box & s1_sgn;
      s2_box      <= s1_box;
      s2_expones  <= s1_expones;
      s2_expzero  <= s1_expzero;
      s2_fraczero <= s1_fraczero;
      s2_fracmsb  <= s1_fracmsb;
    end
  end

  fclassify u_fclassify (
    .sgn      (s2_sgn),
    .expones  (s2_expones),
    .expzero  (s2_expzero),
    .fraczero (s2_fraczero),
    .fracmsb  (s2_fracmsb),
    .boxok    (s2_box),
    .classres (s2_class)
  );

  // Gating by v2 keeps outputs at zero while empty or in reset without resetting data.
  assign OutValid = v2;
  assign Sgn      = v2 & s2_sgn;
  assign BoxOk    = v2 & s2_box;
  assign ClassRes = v2 ? s2_class : '0;

endmodule

// File: tb/tb_fnanunbox.sv
// tb/tb_fnanunbox.sv - directed and random self-checking bench for fnanunbox
module tb_fnanunbox;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [63:0] X;
  logic        Fmt;
  logic        OutValid;
  logic        OutReady;
  logic        Sgn;
  logic        BoxOk;
  logic [9:0]  ClassRes;

  int errors = 0;
  int checks = 0;
  int nout   = 0;
  logic [11:0] sbq[$];
  logic        prev_stall = 1'b0;
  logic [11:0] prev_out   = '0;

  always #5 clk = ~clk;

  fnanunbox dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .X(X), .Fmt(Fmt), .OutValid(OutValid), .OutReady(OutReady),
    .Sgn(Sgn), .BoxOk(BoxOk), .ClassRes(ClassRes)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {sgn, boxok, class[9:0]}
  function automatic logic [11:0] model(input logic [63:0] x, input logic fmt);
    logic s, einf, ez, fz, fm;
    int bitpos;
    if (!fmt) begin
      if (x[63:32] != 32'hFFFF_FFFF) return {2'b00, 10'h200};
      s = x[31]; einf = (x[30:23] == 8'hFF); ez = (x[30:23] == 8'h00);
      fz = (x[22:0] == 23'd0); fm = x[22];
    end else begin
      s = x[63]; einf = (x[62:52] == 11'h7FF); ez = (x[62:52] == 11'h000);
      fz = (x[51:0] == 52'd0); fm = x[51];
    end
    if (einf && fz)      bitpos = s ? 0 : 7;
    else if (einf && fm) bitpos = 9;
    else if (einf)       bitpos = 8;
    else if (ez && fz)   bitpos = s ? 3 : 4;
    else if (ez)         bitpos = s ? 2 : 5;
    else                 bitpos = s ? 1 : 6;
    return {s, 1'b1, 10'(1 << bitpos)};
  endfunction

  // One clock of stimulus with scoreboard, one-hot and stall-hold checking.
  task automatic tick(input logic iv, input logic [63:0] x, input logic fmt,
                      input logic ordy, output logic acc);
    @(negedge clk);
    InValid = iv; X = x; Fmt = fmt; OutReady = ordy;
    #1;
    if (prev_stall) check("hold", {Sgn, BoxOk, ClassRes}, prev_out);
    if (OutValid) check("onehot", $countones(ClassRes), 1);
    acc = iv && InReady;
    if (acc) sbq.push_back(model(x, fmt));
    if (OutValid && OutReady) begin
      nout++;
      if (sbq.size() == 0) check("spurious_out", 1, 0);
      else check("order", {Sgn, BoxOk, ClassRes}, sbq.pop_front());
    end
    prev_stall = OutValid && !OutReady;
    prev_out   = {Sgn, BoxOk, ClassRes};
  endtask

  task automatic single(input string tag, input logic [63:0] x, input logic fmt,
                        input logic [11:0] exp);
    @(negedge clk);
    InValid = 1'b1; X = x; Fmt = fmt; OutReady = 1'b1;
    @(negedge clk);
    InValid = 1'b0; X = '0; Fmt = ~fmt;
    check({tag, "_lat1"}, OutValid, 0);
    @(negedge clk);
    check({tag, "_valid"}, OutValid, 1);
    check(tag, {Sgn, BoxOk, ClassRes}, exp);
  endtask

  logic [63:0] svals [4];
  logic        sfmts [4];
  logic        acc;
  int          idx;
  int          naccept;
  int          cyc;
  int          r;
  logic [63:0] rx;
  logic        rf;

  initial begin
    reset = 1'b1; InValid = 1'b0; X = '0; Fmt = 1'b0; OutReady = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outvalid", OutValid, 0);
    check("rst_inready", InReady, 0);
    check("rst_outs", {Sgn, BoxOk, ClassRes}, 12'h000);
    reset = 1'b0;
    #1;
    check("post_rst_inready", InReady, 1);

    single("f0_one",     64'hFFFFFFFF_3F800000, 1'b0, {1'b0, 1'b1, 10'h040});
    single("f0_unboxed", 64'h00000000_BF800000, 1'b0, {1'b0, 1'b0, 10'h200});
    single("f0_nearbox", 64'hFFFFFFFE_00000000, 1'b0, {1'b0, 1'b0, 10'h200});
    single("f0_qnan",    64'hFFFFFFFF_7FC00000, 1'b0, {1'b0, 1'b1, 10'h200});
    single("f0_negsub",  64'hFFFFFFFF_80000001, 1'b0, {1'b1, 1'b1, 10'h004});
    single("f1_negzero", 64'h80000000_00000000, 1'b1, {1'b1, 1'b1, 10'h008});
    single("f1_snan",    64'h7FF00000_00000001, 1'b1, {1'b0, 1'b1, 10'h100});
    single("f1_neginf",  64'hFFF00000_00000000, 1'b1, {1'b1, 1'b1, 10'h001});
    single("f1_possub",  64'h000FFFFF_FFFFFFFF, 1'b1, {1'b0, 1'b1, 10'h020});
    single("f1_negqnan", 64'hFFF80000_00000000, 1'b1, {1'b1, 1'b1, 10'h200});
    single("f1_posnorm", 64'h3FF00000_00000000, 1'b1, {1'b0, 1'b1, 10'h040});
    @(negedge clk);
    OutReady = 1'b1;
    #1;
    check("idle_outvalid", OutValid, 0);

    // Four back-to-back values, OutReady low on cycles 2..5
    svals[0] = 64'hFFFFFFFF_3F800000; sfmts[0] = 1'b0;
    svals[1] = 64'hFFF00000_00000000; sfmts[1] = 1'b1;
    svals[2] = 64'h12345678_00000000; sfmts[2] = 1'b0;
    svals[3] = 64'h000FFFFF_FFFFFFFF; sfmts[3] = 1'b1;
    idx = 0; nout = 0; prev_stall = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick(idx < 4, (idx < 4) ? svals[idx] : 64'd0, (idx < 4) ? sfmts[idx] : 1'b0,
           !(c >= 2 && c <= 5), acc);
      if (c == 2) begin
        check("stall_accepts", idx, 2);
        check("stall_inready", InReady, 0);
      end
      if (acc) idx++;
    end
    check("stall_all_in", idx, 4);
    check("stall_all_out", nout, 4);
    check("stall_sb_empty", sbq.size(), 0);

    // Reset with two entries in flight
    tick(1'b1, 64'hFFFFFFFF_00000000, 1'b0, 1'b0, acc);
    tick(1'b1, 64'h80000000_00000000, 1'b1, 1'b0, acc);
    @(negedge clk);
    reset = 1'b1; InValid = 1'b1; OutReady = 1'b0;
    #1;
    check("midrst_inready", InReady, 0);
    @(negedge clk);
    check("midrst_outvalid", OutValid, 0);
    reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    #1;
    check("midrst_inready_after", InReady, 1);
    sbq.delete();
    prev_stall = 1'b0;
    nout = 0;
    repeat (6) tick(1'b0, 64'd0, 1'b0, 1'b1, acc);
    check("midrst_no_stale", nout, 0);

    // Random stream
    naccept = 0; cyc = 0; nout = 0;
    while (naccept < 10000 && cyc < 60000) begin
      r  = $urandom_range(0, 7);
      rf = 1'($urandom_range(0, 1));
      rx = {$urandom, $urandom};
      if (!rf && r < 6) rx[63:32] = 32'hFFFF_FFFF;
      if (r == 0) begin
        if (rf) rx[62:52] = 11'h7FF; else rx[30:23] = 8'hFF;
      end else if (r == 1) begin
        if (rf) rx[62:52] = 11'h000; else rx[30:23] = 8'h00;
      end else if (r == 2) begin
        if (rf) rx[50:0] = '0; else rx[21:0] = '0;
      end
      tick($urandom_range(0, 3) != 0, rx, rf, $urandom_range(0, 2) != 0, acc);
      if (acc) naccept++;
      cyc++;
    end
    check("rand_budget", naccept, 10000);
    repeat (4) tick(1'b0, 64'd0, 1'b0, 1'b1, acc);
    check("rand_drained", sbq.size(), 0);
    check("rand_count", nout, naccept);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
